button_pulse_gen: RTL and testbench

Conditions one raw board pushbutton into clean single-cycle strobes for the snake game's counters and direction logic. It sits directly upstream of the 5-bit wrap counter and drives that counter's enable input. Processing chain: 2-flop synchronizer, then integrating debouncer, then edge-pulse generation, then hold-to-repeat FSM. Holding a button steps the counter at a steady rate instead of once per press.

---
 rtl/button_pulse_gen.sv | 146 ++++++++++++++
 tb/tb_button_pulse_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_pulse_gen.sv
// button_pulse_gen: turns one raw, bouncing pushbutton into clean one-cycle
// strobes. Chain: 2-flop synchronizer -> integrating debouncer -> edge pulses
// -> hold-to-repeat FSM. press_pulse drives the downstream counter enable.
module button_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int REPEAT_EN       = 1,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_raw,
    output logic press_pulse,
    output logic release_pulse,
    output logic btn_state,
    output logic held
);

    localparam int CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_btn_state;
    logic             r_press;
    logic             r_release;
    logic             r_held;
    logic [TMR_W-1:0] r_timer;
    state_t           r_state;

    logic w_pressed;
    logic w_commit;
    logic w_rise;
    logic w_fall;
    logic w_rep_due;

    // Everything downstream of the pin works in "1 = pressed" polarity.
    assign w_pressed = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    // The debounced level flips on the edge where the mismatch run completes;
    // rise/fall are that same edge, so pulses and FSM moves line up with it.
    assign w_commit = (r_s2 != r_btn_state) && (r_cnt == CNT_LAST);
    assign w_rise   = w_commit & r_s2;
    assign w_fall   = w_commit & ~r_s2;

    // A repeat is due when the running timer reaches the end of its interval.
    assign w_rep_due = ((r_state == ST_DELAY)  && (r_timer == DELAY_LAST)) ||
                       ((r_state == ST_REPEAT) && (r_timer == PERIOD_LAST));

    // Two-flop synchronizer for the asynchronous pin; resets to not-pressed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= w_pressed;
            r_s2 <= r_s1;
        end
    end

    // Integrating debouncer: any sample agreeing with the current level restarts the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_btn_state <= 1'b0;
        end else if (r_s2 == r_btn_state) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_btn_state <= r_s2;
            r_cnt       <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Edge pulses and hold-to-repeat FSM; release takes priority over a due repeat.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_press   <= w_rise | (w_rep_due & ~w_fall);
            r_release <= w_fall;
            case (r_state)
                ST_IDLE: begin
                    r_timer <= '0;
                    r_held  <= 1'b0;
                    if (w_rise && (REPEAT_EN != 0)) begin
                        r_state <= ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (w_fall) begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                        r_held  <= 1'b0;
                    end else if (r_timer == DELAY_LAST) begin
                        r_state <= ST_REPEAT;
                        r_timer <= '0;
                        r_held  <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (w_fall) begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                        r_held  <= 1'b0;
                    end else if (r_timer == PERIOD_LAST) begin
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_timer <= '0;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign btn_state     = r_btn_state;
    assign held          = r_held;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Testbench for button_pulse_gen: vector table, hand-written corner cases and
// random stimulus, all compared against a behavioural model of the button rules.
module tb_button_pulse_gen;

    localparam int DEB    = 4;
    localparam int DELAY  = 10;
    localparam int PERIOD = 3;

    logic clock;
    logic reset_n;
    logic btn_raw;
    logic press_pulse;
    logic release_pulse;
    logic btn_state;
    logic held;

    int checks = 0;
    int errors = 0;

    button_pulse_gen #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_PERIOD  (PERIOD),
        .REPEAT_EN      (1),
        .BTN_ACTIVE_LOW (1)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .btn_raw      (btn_raw),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .btn_state    (btn_state),
        .held         (held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    // q holds the pressed-level samples of the last DEB+1 edges (oldest first).
    // The synchronizer delays by two edges, so at edge e the debouncer sees the
    // samples from edges e-DEB-1 .. e-2, i.e. q[0..DEB-1]. The level flips when
    // all of them disagree with it. Repeats are timed from the press edge.
    logic q[$];
    logic m_state, m_press, m_rel, m_held;
    int   m_k;

    task automatic model_reset();
        q.delete();
        for (int j = 0; j < DEB + 1; j++) q.push_back(1'b0);
        m_state = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_held = 1'b0; m_k = 0;
    endtask

    task automatic model_step(input logic p);
        logic flip;
        flip = 1'b1;
        for (int j = 0; j < DEB; j++) if (q[j] == m_state) flip = 1'b0;
        q.push_back(p);
        void'(q.pop_front());
        m_press = 1'b0; m_rel = 1'b0;
        if (flip && !m_state) begin
            m_state = 1'b1; m_k = 0; m_press = 1'b1; m_held = 1'b0;
        end else if (flip && m_state) begin
            m_state = 1'b0; m_rel = 1'b1; m_held = 1'b0;
        end else if (m_state) begin
            m_k++;
            m_press = (m_k >= DELAY) && (((m_k - DELAY) % PERIOD) == 0);
            m_held  = (m_k >= DELAY);
        end else begin
            m_held = 1'b0;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_press"}, press_pulse, 1'b0);
        chk({tag, "_release"}, release_pulse, 1'b0);
        chk({tag, "_state"}, btn_state, 1'b0);
        chk({tag, "_held"}, held, 1'b0);
    endtask

    // Drive the pin, take one edge, advance the model, compare 1 ns later.
    task automatic tick(input logic r);
        btn_raw = r;
        @(posedge clock);
        if (!reset_n) model_reset();
        else model_step(~r);
        #1;
        chk("model_press", press_pulse, m_press);
        chk("model_release", release_pulse, m_rel);
        chk("model_state", btn_state, m_state);
        chk("model_held", held, m_held);
    endtask

    task automatic reset_now();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        #2 reset_n = 1'b1;
    endtask

    typedef struct {
        logic raw;
        logic press;
        logic rel;
        logic state;
        logic held;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic lvl;
        int   len;
        int   cyc;

        reset_n = 1'b0;
        btn_raw = 1'b1;
        model_reset();

        // Reset held with the pin toggling: outputs stay 0.
        for (int i = 0; i < 10; i++) begin
            tick(logic'(i % 2));
            chk_zero("in_reset");
        end
        btn_raw = 1'b1;
        release_reset();
        for (int i = 0; i < 20; i++) begin
            tick(1'b1);
            chk_zero("after_reset");
        end

        // Clean press then release, as a vector table.
        for (int i = 0; i < 16; i++) begin
            tbl[i].raw   = (i < 8) ? 1'b0 : 1'b1;
            tbl[i].press = (i == 5);
            tbl[i].rel   = (i == 13);
            tbl[i].state = (i >= 5) && (i < 13);
            tbl[i].held  = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            tick(tbl[i].raw);
            chk("tbl_press", press_pulse, tbl[i].press);
            chk("tbl_release", release_pulse, tbl[i].rel);
            chk("tbl_state", btn_state, tbl[i].state);
            chk("tbl_held", held, tbl[i].held);
        end
        for (int i = 0; i < 6; i++) tick(1'b1);

        // Bounce: 3 low, 1 high, 3 low, then high -- never accepted.
        for (int i = 0; i < 17; i++) begin
            tick((i < 3 || (i >= 4 && i < 7)) ? 1'b0 : 1'b1);
            chk_zero("bounce");
        end

        // Hold: press pulse at P=5, repeats at P+10, P+13, ... ; held from P+10.
        for (int i = 0; i < 36; i++) begin
            tick(1'b0);
            chk("hold_press", press_pulse,
                (i == 5) || (i >= 15 && ((i - 15) % 3) == 0));
            chk("hold_held", held, (i >= 15));
        end
        for (int i = 0; i < 12; i++) tick(1'b1);

        // Release landing on a due repeat (edge 21): only release fires.
        for (int i = 0; i < 26; i++) begin
            tick((i < 16) ? 1'b0 : 1'b1);
            if (i == 18) begin
                chk("bound_rep_press", press_pulse, 1'b1);
                chk("bound_rep_held", held, 1'b1);
            end
            if (i == 21) begin
                chk("bound_press", press_pulse, 1'b0);
                chk("bound_release", release_pulse, 1'b1);
                chk("bound_held", held, 1'b0);
                chk("bound_state", btn_state, 1'b0);
            end
        end

        // Mid-hold reset at P+14, button kept down throughout.
        for (int i = 0; i < 20; i++) tick(1'b0);
        chk("midrst_pre_held", held, 1'b1);
        reset_now();
        chk_zero("midrst_async");
        tick(1'b0);
        tick(1'b0);
        release_reset();
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            chk("midrst_press", press_pulse, (i == 5) || (i == 15) || (i == 18));
            chk("midrst_state", btn_state, (i >= 5));
        end
        for (int i = 0; i < 12; i++) tick(1'b1);

        // Random pin activity: short bounces and long holds against the model.
        lvl = 1'b1;
        cyc = 0;
        while (cyc < 2500) begin
            lvl = ~lvl;
            if ($urandom_range(0, 3) == 0) len = $urandom_range(12, 45);
            else len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) tick(lvl);
            cyc += len;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
